// File: rtl/vx_cache_bank_dispatch.sv
// vx_cache_bank_dispatch: routes core request lanes to cache banks with per-bank round-robin
// arbitration, same-line port merging and a one-entry output register per bank.
module vx_cache_bank_dispatch #(
  parameter int NUM_REQS   = 4,
  parameter int NUM_BANKS  = 4,
  parameter int NUM_PORTS  = 2,
  parameter int LINE_SIZE  = 16,
  parameter int WORD_SIZE  = 4,
  parameter int ADDR_WIDTH = 26,
  parameter int TAG_WIDTH  = 8,
  parameter int CTR_WIDTH  = 32,
  localparam int WPL = LINE_SIZE / WORD_SIZE,
  localparam int WSB = $clog2(WPL),
  localparam int BSB = $clog2(NUM_BANKS),
  localparam int LAW = ADDR_WIDTH - BSB - WSB,
  localparam int WSW = (WSB > 0) ? WSB : 1,
  localparam int BSW = (BSB > 0) ? BSB : 1,
  localparam int IW  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  localparam int DW  = WORD_SIZE * 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQS-1:0]                 i_core_req_valid,
  input  logic [NUM_REQS-1:0]                 i_core_req_rw,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]      i_core_req_addr,
  input  logic [NUM_REQS*WORD_SIZE-1:0]       i_core_req_byteen,
  input  logic [NUM_REQS*DW-1:0]              i_core_req_data,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]       i_core_req_tag,
  output logic [NUM_REQS-1:0]                 o_core_req_ready,
  output logic [NUM_BANKS-1:0]                o_per_bank_req_valid,
  output logic [NUM_BANKS-1:0]                o_per_bank_req_rw,
  output logic [NUM_BANKS*NUM_PORTS-1:0]      o_per_bank_req_pmask,
  output logic [NUM_BANKS*LAW-1:0]            o_per_bank_req_addr,
  output logic [NUM_BANKS*NUM_PORTS*WSW-1:0]  o_per_bank_req_wsel,
  output logic [NUM_BANKS*NUM_PORTS*IW-1:0]   o_per_bank_req_idx,
  output logic [NUM_BANKS*NUM_PORTS*WORD_SIZE-1:0] o_per_bank_req_byteen,
  output logic [NUM_BANKS*NUM_PORTS*DW-1:0]   o_per_bank_req_data,
  output logic [NUM_BANKS*NUM_PORTS*TAG_WIDTH-1:0] o_per_bank_req_tag,
  input  logic [NUM_BANKS-1:0]                i_per_bank_req_ready,
  output logic [CTR_WIDTH-1:0]                o_bank_stalls
);
  logic [NUM_REQS-1:0][BSW-1:0]       w_bank;
  logic [NUM_REQS-1:0][WSW-1:0]       w_wsel;
  logic [NUM_REQS-1:0][LAW-1:0]       w_line;
  logic [NUM_REQS-1:0][WORD_SIZE-1:0] w_be;
  logic [NUM_REQS-1:0][DW-1:0]        w_data;
  logic [NUM_REQS-1:0][TAG_WIDTH-1:0] w_tag;
  logic [NUM_BANKS-1:0][NUM_REQS-1:0]           w_sel;
  logic [NUM_BANKS-1:0][NUM_PORTS-1:0]          w_pmask;
  logic [NUM_BANKS-1:0][NUM_PORTS-1:0][IW-1:0]  w_plane;
  logic [NUM_BANKS-1:0][LAW-1:0]                w_bline;
  logic [NUM_BANKS-1:0][IW-1:0]                 w_nrr;
  logic [NUM_BANKS-1:0]                         w_brw, w_load;
  logic [CTR_WIDTH:0]                           w_sum;
  logic [NUM_BANKS-1:0][IW-1:0]                 r_rr;
  logic [NUM_BANKS-1:0]                         r_valid, r_rw;
  logic [NUM_BANKS*NUM_PORTS-1:0]               r_pmask;
  logic [NUM_BANKS*LAW-1:0]                     r_addr;
  logic [NUM_BANKS*NUM_PORTS*WSW-1:0]           r_wsel;
  logic [NUM_BANKS*NUM_PORTS*IW-1:0]            r_idx;
  logic [NUM_BANKS*NUM_PORTS*WORD_SIZE-1:0]     r_be;
  logic [NUM_BANKS*NUM_PORTS*DW-1:0]            r_data;
  logic [NUM_BANKS*NUM_PORTS*TAG_WIDTH-1:0]     r_tag;
  logic [CTR_WIDTH-1:0]                         r_stalls;

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_dec
    assign w_wsel[i] = (WSB > 0) ? i_core_req_addr[i*ADDR_WIDTH +: WSW] : '0;
    assign w_bank[i] = (BSB > 0) ? i_core_req_addr[i*ADDR_WIDTH+WSB +: BSW] : '0;
    assign w_line[i] = i_core_req_addr[i*ADDR_WIDTH+WSB+BSB +: LAW];
    assign w_be[i]   = i_core_req_byteen[i*WORD_SIZE +: WORD_SIZE];
    assign w_data[i] = i_core_req_data[i*DW +: DW];
    assign w_tag[i]  = i_core_req_tag[i*TAG_WIDTH +: TAG_WIDTH];
  end

  // An empty pmask means the bank has no winner yet; the first match in RR order fixes line and rw.
  always_comb begin
    w_sel = '0;
    w_pmask = '0;
    w_plane = '0;
    w_bline = '0;
    w_brw = '0;
    w_nrr = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      for (int k = 0; k < NUM_REQS; k++) begin
        int l, p;
        l = (int'(r_rr[b]) + k) % NUM_REQS;
        p = l % NUM_PORTS;
        if (i_core_req_valid[l] && w_bank[l] == BSW'(b) && (w_pmask[b] == '0 ||
            (w_line[l] == w_bline[b] && i_core_req_rw[l] == w_brw[b] && !w_pmask[b][p]))) begin
          if (w_pmask[b] == '0) begin
            w_bline[b] = w_line[l];
            w_brw[b] = i_core_req_rw[l];
            w_nrr[b] = IW'((l + 1) % NUM_REQS);
          end
          w_sel[b][l] = 1'b1;
          w_pmask[b][p] = 1'b1;
          w_plane[b][p] = IW'(l);
        end
      end
  end

  always_comb begin
    o_core_req_ready = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_load[b] = (|w_pmask[b]) && (!r_valid[b] || i_per_bank_req_ready[b]);
      o_core_req_ready = o_core_req_ready | (w_sel[b] & {NUM_REQS{w_load[b]}});
    end
    o_core_req_ready = o_core_req_ready & {NUM_REQS{rst_n}};
    w_sum = {1'b0, r_stalls} + (CTR_WIDTH+1)'($countones(i_core_req_valid & ~o_core_req_ready));
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_valid  <= '0;
      r_pmask  <= '0;
      r_rr     <= '0;
      r_stalls <= '0;
    end else begin
      r_stalls <= w_sum[CTR_WIDTH] ? '1 : w_sum[CTR_WIDTH-1:0];
      for (int b = 0; b < NUM_BANKS; b++)
        if (w_load[b]) begin
          r_valid[b] <= 1'b1;
          r_pmask[b*NUM_PORTS +: NUM_PORTS] <= w_pmask[b];
          r_rr[b] <= w_nrr[b];
        end else if (i_per_bank_req_ready[b]) begin
          r_valid[b] <= 1'b0;
        end
    end

  // Payload needs no reset; unused ports keep whatever they last carried.
  always_ff @(posedge clk)
    for (int b = 0; b < NUM_BANKS; b++)
      if (w_load[b]) begin
        r_rw[b] <= w_brw[b];
        r_addr[b*LAW +: LAW] <= w_bline[b];
        for (int p = 0; p < NUM_PORTS; p++)
          if (w_pmask[b][p]) begin
            r_wsel[(b*NUM_PORTS+p)*WSW +: WSW]            <= w_wsel[w_plane[b][p]];
            r_idx[(b*NUM_PORTS+p)*IW +: IW]               <= w_plane[b][p];
            r_be[(b*NUM_PORTS+p)*WORD_SIZE +: WORD_SIZE]  <= w_be[w_plane[b][p]];
            r_data[(b*NUM_PORTS+p)*DW +: DW]              <= w_data[w_plane[b][p]];
            r_tag[(b*NUM_PORTS+p)*TAG_WIDTH +: TAG_WIDTH] <= w_tag[w_plane[b][p]];
          end
      end

  assign o_per_bank_req_valid  = r_valid;
  assign o_per_bank_req_rw     = r_rw;
  assign o_per_bank_req_pmask  = r_pmask;
  assign o_per_bank_req_addr   = r_addr;
  assign o_per_bank_req_wsel   = r_wsel;
  assign o_per_bank_req_idx    = r_idx;
  assign o_per_bank_req_byteen = r_be;
  assign o_per_bank_req_data   = r_data;
  assign o_per_bank_req_tag    = r_tag;
  assign o_bank_stalls         = r_stalls;
endmodule

// File: tb/tb_vx_cache_bank_dispatch.sv
// tb_vx_cache_bank_dispatch: directed scenarios plus random traffic checked every cycle
// against a queue-based reference model of the dispatcher.
module tb_vx_cache_bank_dispatch;
  localparam int NR = 4, NB = 4, NP = 2, AW = 26, LAW = 22;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0] v, rw, rdy, rdy_s;
  logic [AW-1:0] addr [NR];
  logic [3:0]    be   [NR];
  logic [31:0]   data [NR];
  logic [7:0]    tag  [NR];
  logic [NR*AW-1:0] addr_f;
  logic [NR*4-1:0]  be_f;
  logic [NR*32-1:0] data_f;
  logic [NR*8-1:0]  tag_f;
  logic [NB-1:0] brdy, bv, brw, bv_s, brw_s;
  logic [NB*NP-1:0] pm, pm_s;
  logic [NB*LAW-1:0] ba, ba_s;
  logic [NB*NP*2-1:0] ws, ws_s, ix, ix_s;
  logic [NB*NP*4-1:0] bbe, bbe_s;
  logic [NB*NP*32-1:0] bd, bd_s;
  logic [NB*NP*8-1:0] bt, bt_s;
  logic [31:0] stalls;
  logic [2:0]  stalls_s;

  always_comb
    for (int i = 0; i < NR; i++) begin
      addr_f[i*AW +: AW] = addr[i];
      be_f[i*4 +: 4]     = be[i];
      data_f[i*32 +: 32] = data[i];
      tag_f[i*8 +: 8]    = tag[i];
    end

  vx_cache_bank_dispatch dut (
    .clk(clk), .rst_n(rst_n), .i_core_req_valid(v), .i_core_req_rw(rw), .i_core_req_addr(addr_f),
    .i_core_req_byteen(be_f), .i_core_req_data(data_f), .i_core_req_tag(tag_f), .o_core_req_ready(rdy),
    .o_per_bank_req_valid(bv), .o_per_bank_req_rw(brw), .o_per_bank_req_pmask(pm),
    .o_per_bank_req_addr(ba), .o_per_bank_req_wsel(ws), .o_per_bank_req_idx(ix),
    .o_per_bank_req_byteen(bbe), .o_per_bank_req_data(bd), .o_per_bank_req_tag(bt),
    .i_per_bank_req_ready(brdy), .o_bank_stalls(stalls));

  // Narrow stall counter instance to reach saturation quickly.
  vx_cache_bank_dispatch #(.CTR_WIDTH(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .i_core_req_valid(v), .i_core_req_rw(rw), .i_core_req_addr(addr_f),
    .i_core_req_byteen(be_f), .i_core_req_data(data_f), .i_core_req_tag(tag_f), .o_core_req_ready(rdy_s),
    .o_per_bank_req_valid(bv_s), .o_per_bank_req_rw(brw_s), .o_per_bank_req_pmask(pm_s),
    .o_per_bank_req_addr(ba_s), .o_per_bank_req_wsel(ws_s), .o_per_bank_req_idx(ix_s),
    .o_per_bank_req_byteen(bbe_s), .o_per_bank_req_data(bd_s), .o_per_bank_req_tag(bt_s),
    .i_per_bank_req_ready(brdy), .o_bank_stalls(stalls_s));

  int checks = 0, errors = 0;
  int m_rr [NB];
  bit m_v [NB];
  bit [NP-1:0] m_pm [NB];
  bit m_rw [NB];
  logic [LAW-1:0] m_a [NB];
  logic [1:0]  m_ws [NB][NP];
  int          m_ix [NB][NP];
  logic [3:0]  m_be [NB][NP];
  logic [31:0] m_d  [NB][NP];
  logic [7:0]  m_t  [NB][NP];
  longint m_st;
  logic [NR-1:0] e_rdy;

  task automatic check(string t, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", t, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      m_rr[b] = 0;
      m_v[b] = 0;
      m_pm[b] = '0;
    end
    m_st = 0;
  endtask

  // Gather each bank's requesters in round-robin order; the head wins, later ones merge if compatible.
  task automatic settle();
    int q[$];
    bit [NP-1:0] used;
    int w, p;
    #2;
    e_rdy = '0;
    for (int b = 0; b < NB; b++) begin
      q.delete();
      for (int k = 0; k < NR; k++)
        if (v[(m_rr[b]+k)%NR] && addr[(m_rr[b]+k)%NR][3:2] == b) q.push_back((m_rr[b]+k)%NR);
      if (q.size() > 0 && (!m_v[b] || brdy[b])) begin
        w = q[0];
        used = '0;
        m_v[b] = 1;
        m_rw[b] = rw[w];
        m_a[b] = addr[w][AW-1:4];
        m_rr[b] = (w + 1) % NR;
        foreach (q[j])
          if (addr[q[j]][AW-1:4] == m_a[b] && rw[q[j]] == m_rw[b] && !used[q[j]%NP]) begin
            p = q[j] % NP;
            used[p] = 1;
            e_rdy[q[j]] = 1;
            m_ws[b][p] = addr[q[j]][1:0];
            m_ix[b][p] = q[j];
            m_be[b][p] = be[q[j]];
            m_d[b][p] = data[q[j]];
            m_t[b][p] = tag[q[j]];
          end
        m_pm[b] = used;
      end else if (brdy[b]) m_v[b] = 0;
    end
    check("core_ready", rdy, e_rdy);
    m_st += $countones(v & ~e_rdy);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int b = 0; b < NB; b++) begin
      check($sformatf("valid[%0d]", b), bv[b], m_v[b]);
      check($sformatf("pmask[%0d]", b), pm[b*NP +: NP], m_pm[b]);
      if (m_v[b]) begin
        check($sformatf("rw[%0d]", b), brw[b], m_rw[b]);
        check($sformatf("addr[%0d]", b), ba[b*LAW +: LAW], m_a[b]);
        for (int p = 0; p < NP; p++)
          if (m_pm[b][p]) begin
            check($sformatf("wsel[%0d][%0d]", b, p), ws[(b*NP+p)*2 +: 2], m_ws[b][p]);
            check($sformatf("idx[%0d][%0d]", b, p), ix[(b*NP+p)*2 +: 2], m_ix[b][p]);
            check($sformatf("byteen[%0d][%0d]", b, p), bbe[(b*NP+p)*4 +: 4], m_be[b][p]);
            check($sformatf("data[%0d][%0d]", b, p), bd[(b*NP+p)*32 +: 32], m_d[b][p]);
            check($sformatf("tag[%0d][%0d]", b, p), bt[(b*NP+p)*8 +: 8], m_t[b][p]);
          end
      end
    end
    check("stalls", stalls, m_st);
    check("stalls_sat", stalls_s, (m_st > 7) ? 7 : m_st);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_ready", rdy, '0);
    check("rst_valid", bv, '0);
    check("rst_stalls", stalls, '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_lane(int i, bit vv, bit r, logic [AW-1:0] a);
    v[i] = vv;
    rw[i] = r;
    addr[i] = a;
    be[i] = 4'($urandom);
    data[i] = $urandom;
    tag[i] = 8'($urandom);
  endtask

  task automatic new_req(int i);
    set_lane(i, $urandom_range(0, 3) != 0, 1'($urandom),
             {AW'($urandom_range(0, 2)), 2'($urandom), 2'($urandom)} & {AW{1'b1}});
  endtask

  initial begin
    for (int i = 0; i < NR; i++) set_lane(i, 0, 0, '0);
    brdy = '1;
    do_reset();
    // all lanes to distinct banks
    for (int i = 0; i < NR; i++) set_lane(i, 1, 0, AW'(i * 4));
    settle();
    check("distinct_ready", rdy, 4'b1111);
    tick();
    check("distinct_valid", bv, 4'b1111);
    // two lanes, same bank, different lines: alternating grants
    do_reset();
    set_lane(0, 1, 0, AW'('h00));
    set_lane(1, 1, 0, AW'('h10));
    set_lane(2, 0, 0, '0);
    set_lane(3, 0, 0, '0);
    for (int c = 0; c < 4; c++) begin
      settle();
      check("rr_grant", rdy, (c % 2) ? 4'b0010 : 4'b0001);
      tick();
    end
    // same line, adjacent words merge into both ports
    do_reset();
    set_lane(0, 1, 0, AW'('h00));
    set_lane(1, 1, 0, AW'('h01));
    settle();
    check("merge_ready", rdy, 4'b0011);
    tick();
    check("merge_pmask", pm[1:0], 2'b11);
    check("merge_wsel", ws[3:0], {2'd1, 2'd0});
    // rw mismatch blocks merging
    do_reset();
    set_lane(0, 1, 1, AW'('h00));
    set_lane(1, 1, 0, AW'('h01));
    settle();
    check("rwmix_ready0", rdy, 4'b0001);
    tick();
    v[0] = 0;
    settle();
    check("rwmix_ready1", rdy, 4'b0010);
    tick();
    check("rwmix_stalls", stalls, 1);
    // bank backpressure for five cycles
    do_reset();
    v = '0;
    set_lane(0, 1, 0, AW'('h00));
    brdy = '0;
    settle();
    tick();
    v = '0;
    set_lane(1, 1, 0, AW'('h10));
    for (int c = 0; c < 5; c++) begin
      settle();
      check("bp_ready", rdy, '0);
      tick();
    end
    check("bp_stalls", stalls, 5);
    brdy = '1;
    settle();
    check("bp_release", rdy, 4'b0010);
    tick();
    // reset while two banks hold entries; rr must return to 0
    do_reset();
    v = '0;
    brdy = '0;
    set_lane(0, 1, 0, AW'('h00));
    set_lane(1, 1, 0, AW'('h04));
    settle();
    tick();
    v = '1;
    set_lane(1, 1, 0, AW'('h10));
    settle();
    tick();
    do_reset();
    brdy = '1;
    v = 4'b0011;
    settle();
    check("post_rst_rr", rdy, 4'b0001);
    tick();
    // random traffic
    do_reset();
    for (int i = 0; i < NR; i++) new_req(i);
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < NB; b++) brdy[b] = $urandom_range(0, 3) != 0;
      settle();
      tick();
      for (int i = 0; i < NR; i++) if (!v[i] || e_rdy[i]) new_req(i);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
